// File: rtl/seg7_scan_ctrl.sv
// ============================================================================
// seg7_scan_ctrl : Avalon-MM multiplexed common-anode 7-segment scan driver
// Rev 1.0
// ============================================================================
`default_nettype none

module seg7_scan_ctrl #(
   parameter int NUM_DIGITS     = 4,
   parameter int PRESCALE_W     = 16,
   parameter int RESET_PRESCALE = 49999,
   parameter int BLANK_CYCLES   = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [1:0]            address,
   input  logic                  chipselect,
   input  logic                  write_n,
   input  logic [31:0]           writedata,
   output logic [31:0]           readdata,
   output logic [6:0]            seg_n,
   output logic                  dp_n,
   output logic [NUM_DIGITS-1:0] dig_n
);

   localparam int DW = 4 * NUM_DIGITS;
   localparam int BW = $clog2(BLANK_CYCLES + 1);

   typedef enum logic [1:0] {
      ST_OFF   = 2'd0,
      ST_DRIVE = 2'd1,
      ST_BLANK = 2'd2
   } state_t;

   state_t                  state;
   logic [2:0]              idx;
   logic [PRESCALE_W-1:0]   cnt;
   logic [BW-1:0]           bcnt;
   logic                    frame_done;

   logic [DW-1:0]           data_q;
   logic                    en;
   logic [NUM_DIGITS-1:0]   blank_mask;
   logic [NUM_DIGITS-1:0]   dp_on;
   logic [PRESCALE_W-1:0]   prescale;

   logic                    wr;
   logic                    fd_clr;
   logic                    last_digit;
   logic [DW-1:0]           nib_sh;
   logic [NUM_DIGITS-1:0]   mask_sh;
   logic [NUM_DIGITS-1:0]   dp_sh;
   logic                    unused_wdata;

   assign wr           = chipselect & ~write_n;
   assign fd_clr       = wr && (address == 2'd3) && writedata[9];
   assign last_digit   = (idx == 3'(NUM_DIGITS - 1));
   assign nib_sh       = data_q >> {idx, 2'b00};
   assign mask_sh      = blank_mask >> idx;
   assign dp_sh        = dp_on >> idx;
   assign unused_wdata = ^writedata;

   function automatic logic [6:0] hex7(input logic [3:0] v);
      case (v)
         4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
         4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
         4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
         4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         data_q     <= '0;
         en         <= 1'b0;
         blank_mask <= '0;
         dp_on      <= '0;
         prescale   <= PRESCALE_W'(RESET_PRESCALE);
      end else if (wr) begin
         case (address)
            2'd0: data_q <= writedata[DW-1:0];
            2'd1: begin
               en         <= writedata[0];
               blank_mask <= writedata[8 +: NUM_DIGITS];
               dp_on      <= writedata[16 +: NUM_DIGITS];
            end
            2'd2: prescale <= writedata[PRESCALE_W-1:0];
            default: ;
         endcase
      end
   end

   // Outputs are gated by the live enable so a disable blanks the display on the very next edge.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= ST_OFF;
         idx        <= '0;
         cnt        <= '0;
         bcnt       <= '0;
         frame_done <= 1'b0;
         seg_n      <= 7'h7F;
         dp_n       <= 1'b1;
         dig_n      <= '1;
      end else begin
         if (fd_clr)
            frame_done <= 1'b0;

         seg_n <= 7'h7F;
         dp_n  <= 1'b1;
         dig_n <= '1;
         if (en && state == ST_DRIVE) begin
            seg_n <= mask_sh[0] ? 7'h7F : hex7(nib_sh[3:0]);
            dp_n  <= mask_sh[0] | ~dp_sh[0];
            for (int i = 0; i < NUM_DIGITS; i++)
               dig_n[i] <= (idx != 3'(i));
         end

         if (!en) begin
            state <= ST_OFF;
            idx   <= '0;
            cnt   <= '0;
            bcnt  <= '0;
         end else begin
            case (state)
               ST_OFF: begin
                  state <= ST_DRIVE;
                  idx   <= '0;
                  cnt   <= '0;
                  bcnt  <= '0;
               end
               ST_DRIVE: begin
                  if (cnt >= prescale) begin
                     state <= ST_BLANK;
                     cnt   <= '0;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               ST_BLANK: begin
                  if (bcnt == BW'(BLANK_CYCLES - 1)) begin
                     bcnt  <= '0;
                     state <= ST_DRIVE;
                     if (last_digit) begin
                        idx        <= '0;
                        frame_done <= 1'b1;
                     end else begin
                        idx <= idx + 1'b1;
                     end
                  end else begin
                     bcnt <= bcnt + 1'b1;
                  end
               end
               default: state <= ST_OFF;
            endcase
         end
      end
   end

   always_comb begin
      readdata = '0;
      case (address)
         2'd0: readdata[DW-1:0] = data_q;
         2'd1: begin
            readdata[0]               = en;
            readdata[8 +: NUM_DIGITS]  = blank_mask;
            readdata[16 +: NUM_DIGITS] = dp_on;
         end
         2'd2: readdata[PRESCALE_W-1:0] = prescale;
         default: begin
            readdata[2:0] = idx;
            readdata[8]   = (state == ST_BLANK);
            readdata[9]   = frame_done;
         end
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
// ============================================================================
// tb_seg7_scan_ctrl : randomized self-checking bench against a slot-arithmetic model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_seg7_scan_ctrl;

   localparam int N  = 4;
   localparam int BC = 4;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [6:0]  seg_n;
   logic        dp_n;
   logic [N-1:0] dig_n;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   seg7_scan_ctrl #(
      .NUM_DIGITS(N), .PRESCALE_W(16), .RESET_PRESCALE(49999), .BLANK_CYCLES(BC)
   ) dut (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(readdata),
      .seg_n(seg_n), .dp_n(dp_n), .dig_n(dig_n)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
      @(posedge clk); #1;
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
      address = a;
      #1 d = readdata;
   endtask

   // Display is a repeating sequence of slots of length P+1+BC per digit; outputs lag the scan state by one cycle.
   task automatic run_scan(input int p, input logic [15:0] d, input logic [31:0] ctrl, input int cycles);
      int L, v, slot, dg, sidx;
      logic [6:0] e_seg;
      logic e_dp, e_blank, e_fd, msk;
      logic [N-1:0] e_dig;
      L = p + 1 + BC;
      bus_write(2'd1, 32'h0);
      bus_write(2'd2, 32'(p));
      bus_write(2'd0, {16'h0, d});
      bus_write(2'd3, 32'h200);
      bus_write(2'd1, ctrl | 32'h1);
      address = 2'd3;
      for (int u = 0; u < cycles; u++) begin
         @(posedge clk); #1;
         e_seg = 7'h7F; e_dp = 1'b1; e_dig = '1;
         if (u > 0) begin
            v    = u - 1;
            slot = v % L;
            dg   = (v / L) % N;
            if (slot <= p) begin
               msk = ctrl[8 + dg];
               e_dig[dg] = 1'b0;
               e_seg = msk ? 7'h7F : seg_tab[(d >> (4 * dg)) & 16'hF];
               e_dp  = msk ? 1'b1 : ~ctrl[16 + dg];
            end
         end
         sidx    = (u / L) % N;
         e_blank = (u % L) > p;
         e_fd    = (u >= N * L);
         check("seg_n", 32'(seg_n), 32'(e_seg));
         check("dp_n", 32'(dp_n), 32'(e_dp));
         check("dig_n", 32'(dig_n), 32'(e_dig));
         check("status", readdata, (32'(e_fd) << 9) | (32'(e_blank) << 8) | 32'(sidx));
      end
   endtask

   task automatic wait_fd(output int at);
      logic [31:0] r;
      at = -1;
      for (int k = 0; k < 200 && at < 0; k++) begin
         @(posedge clk); #1;
         bus_read(2'd3, r);
         if (r[9]) at = cyc;
      end
      if (at < 0) check("fd_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      logic [31:0] r;
      int c1, c2, p;
      logic [31:0] rd, rc;

      reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = 2'd0; writedata = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_seg", 32'(seg_n), 32'h7F);
      check("rst_dig", 32'(dig_n), 32'hF);
      check("rst_dp", 32'(dp_n), 32'h1);
      bus_read(2'd2, r); check("rst_prescale", r, 32'd49999);
      bus_read(2'd3, r); check("rst_status", r, 32'h0);
      reset_n = 1'b1;

      run_scan(3, 16'h8A10, 32'h1, 70);
      run_scan(3, 16'h8A10, 32'h0000_0201, 40);
      run_scan(3, 16'h8A10, 32'h0001_0001, 40);

      // frame period and W1C behaviour
      run_scan(3, 16'h8A10, 32'h1, 0);
      wait_fd(c1);
      bus_write(2'd3, 32'h100);
      bus_read(2'd3, r); check("w1c_ignore", 32'(r[9]), 32'h1);
      bus_write(2'd3, 32'h200);
      bus_read(2'd3, r); check("w1c_clear", 32'(r[9]), 32'h0);
      wait_fd(c2);
      check("frame_period", 32'(c2 - c1), 32'd32);
      bus_write(2'd3, 32'h200);
      for (int k = 0; k < 100 && cyc < c2 + 31; k++) begin
         @(posedge clk); #1;
      end
      bus_write(2'd3, 32'h200);
      bus_read(2'd3, r); check("set_wins", 32'(r[9]), 32'h1);

      // abort during digit 2
      run_scan(3, 16'h8A10, 32'h1, 17);
      bus_write(2'd1, 32'h0);
      check("abort_pre_dig", 32'(dig_n), 32'hB);
      @(posedge clk); #1;
      check("abort_seg", 32'(seg_n), 32'h7F);
      check("abort_dig", 32'(dig_n), 32'hF);
      check("abort_dp", 32'(dp_n), 32'h1);
      bus_read(2'd3, r); check("abort_status", r, 32'h0);
      run_scan(3, 16'h8A10, 32'h1, 20);

      for (int it = 0; it < 6; it++) begin
         p = $urandom_range(0, 5);
         run_scan(p, 16'($urandom), ($urandom & 32'h000F_0F00) | 32'h1, 2 * N * (p + 1 + BC) + 3);
      end

      // lowering PRESCALE below the running count ends the dwell on the next edge
      run_scan(100, 16'h1234, 32'h1, 51);
      bus_write(2'd2, 32'd10);
      bus_read(2'd3, r); check("ps_still_drive", r, 32'h000);
      @(posedge clk); #1;
      bus_read(2'd3, r); check("ps_blank", r, 32'h100);
      bus_write(2'd0, 32'hFFFF_FFFF);
      bus_read(2'd0, rd); check("data_upper0", rd, 32'h0000_FFFF);
      bus_write(2'd2, 32'hFFFF_FFFF);
      bus_read(2'd2, r); check("ps_upper0", r, 32'h0000_FFFF);
      bus_write(2'd1, 32'hFFFF_FFFF);
      bus_read(2'd1, rc); check("ctrl_upper0", rc, 32'h000F_0F01);

      // reset mid-scan
      repeat (5) @(posedge clk);
      @(negedge clk); reset_n = 1'b0;
      @(posedge clk); #1; reset_n = 1'b1;
      check("mrst_seg", 32'(seg_n), 32'h7F);
      check("mrst_dig", 32'(dig_n), 32'hF);
      bus_read(2'd3, r); check("mrst_status", r, 32'h0);
      bus_read(2'd2, r); check("mrst_prescale", r, 32'd49999);
      bus_read(2'd0, r); check("mrst_data", r, 32'h0);
      bus_read(2'd1, r); check("mrst_ctrl", r, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
